// File: rtl/uart_irq_scheduler.sv
// Edge-detecting sticky interrupt collector with masking, priority encode and coalescing hold-off.
// Pending is set on the sampling edge; id/irq follow one edge later (plus coalesce); no backpressure, clear is a W1C strobe.
module uart_irq_scheduler #(
  parameter int EVENTS  = 8,
  parameter int TIMER_W = 16,
  parameter int ID_W    = (EVENTS > 1) ? $clog2(EVENTS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [EVENTS-1:0]     i_events,
  input  logic [2*EVENTS-1:0]   i_edge_sel,
  input  logic [EVENTS-1:0]     i_mask,
  input  logic                  i_clr_valid,
  input  logic [EVENTS-1:0]     i_clr_bits,
  input  logic [TIMER_W-1:0]    i_coalesce,
  output logic [EVENTS-1:0]     o_pending,
  output logic                  o_irq,
  output logic [ID_W-1:0]       o_irq_id,
  output logic                  o_irq_id_valid
);

  typedef enum logic [1:0] {IDLE, HOLD, ASSERT} state_t;

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  cnt, cnt_nxt;
  logic [EVENTS-1:0]   prev, pending, hit, rise, fall, mp, clr;
  logic                primed;
  logic [ID_W-1:0]     id_nxt, irq_id;
  logic                id_valid;

  assign rise = ~prev & i_events;
  assign fall = prev & ~i_events;
  assign clr  = i_clr_valid ? i_clr_bits : '0;
  assign mp   = pending & i_mask;

  // primed suppresses the spurious edge against the reset value of prev.
  always_comb begin
    hit = '0;
    for (int i = 0; i < EVENTS; i++) begin
      case (i_edge_sel[2*i +: 2])
        2'b01:   hit[i] = rise[i];
        2'b10:   hit[i] = fall[i];
        2'b11:   hit[i] = rise[i] | fall[i];
        default: hit[i] = 1'b0;
      endcase
    end
    if (!primed) hit = '0;
  end

  always_comb begin
    id_nxt = '0;
    for (int i = EVENTS - 1; i >= 0; i--) begin
      if (mp[i]) id_nxt = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|mp) begin
          if (i_coalesce == '0) begin
            state_nxt = ASSERT;
          end else begin
            cnt_nxt   = i_coalesce - TIMER_W'(1);
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!(|mp))          state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = ASSERT;
        else                 cnt_nxt   = cnt - TIMER_W'(1);
      end
      ASSERT: begin
        if (!(|mp)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      prev     <= '0;
      primed   <= 1'b0;
      pending  <= '0;
      irq_id   <= '0;
      id_valid <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
    end else begin
      prev     <= i_events;
      primed   <= 1'b1;
      pending  <= (pending & ~clr) | hit;
      irq_id   <= id_nxt;
      id_valid <= |mp;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
    end
  end

  assign o_pending      = pending;
  assign o_irq          = (state == ASSERT);
  assign o_irq_id       = irq_id;
  assign o_irq_id_valid = id_valid;

endmodule

// File: doc/uart_irq_scheduler.md
Name: uart_irq_scheduler

Overview:
Interrupt controller for the UART core. It takes the core's raw status/event lines (rx_valid, tx_empty, fifo thresholds, framing/parity errors, ...) and detects a per-line selectable edge on each. Detected edges latch into sticky pending bits, which are masked and priority-encoded. A single IRQ output drives the host, with optional coalescing delay. It sits between the UART datapath status signals and the register block, which supplies mask, edge select, coalescing and write-1-to-clear.

Parameters:
EVENTS, 8, number of event lines (1..32)
TIMER_W, 16, width of coalescing counter
ID_W, $clog2(EVENTS) (min 1), width of IRQ id output

Ports:
i_clk  input  1  clock
i_nrst  input  1  reset, asynchronous, active-low
i_events  input  EVENTS  raw event/status levels, synchronous to i_clk
i_edge_sel  input  2*EVENTS  per line [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both
i_mask  input  EVENTS  1 = event may raise IRQ; pending still latches when 0
i_clr_valid  input  1  one-cycle clear strobe from register block
i_clr_bits  input  EVENTS  write-1-to-clear pattern, used when i_clr_valid=1
i_coalesce  input  TIMER_W  cycles to hold off IRQ after first masked pending; 0 = immediate
o_pending  output  EVENTS  sticky pending bits (unmasked view)
o_irq  output  1  interrupt request, registered
o_irq_id  output  ID_W  index of lowest-numbered masked pending bit
o_irq_id_valid  output  1  1 when any masked pending bit is set

Behaviour:
- Reset (async assert, sync release): all outputs 0, pending=0, prev-sample=0, primed=0, FSM=IDLE, counter=0.
- Edge detect: prev register samples i_events every cycle. primed goes 1 on the first clock after reset release. While primed=0, no edges are generated, so lines already high at reset release do not fire.
- Edges: rise[i] = !prev[i] & i_events[i]. fall[i] = prev[i] & !i_events[i]. hit[i] = (sel=01 & rise) | (sel=10 & fall) | (sel=11 & (rise|fall)). sel=00 gives hit=0.
- Pending update each clock: pending <= (pending & ~(i_clr_valid ? i_clr_bits : 0)) | hit. A set wins over a simultaneous clear on the same bit.
- Latency: an edge at the input sampled at edge N sets o_pending at edge N. It is visible in the cycle after the input change.
- Masked pending: mp = pending & i_mask. Mask changes take effect combinationally on mp. The outputs derived from mp are registered.
- o_irq_id / o_irq_id_valid are registered from mp each cycle, one cycle behind pending. With mp=0 the id is 0 and valid is 0.
- FSM IDLE -> if mp!=0: if i_coalesce==0 go ASSERT, else load cnt=i_coalesce-1 and go HOLD.
- FSM HOLD -> if mp==0 go IDLE. Else if cnt==0 go ASSERT. Else cnt--. i_coalesce changes during HOLD are ignored.
- FSM ASSERT -> o_irq=1 (registered, state==ASSERT). If mp==0 go IDLE, and o_irq drops the following cycle. New events arriving while in ASSERT keep the IRQ asserted with no re-coalescing.
- o_irq rises exactly 1 + i_coalesce cycles after the first cycle mp!=0 when starting from IDLE.
- Masking all pending bits while in HOLD or ASSERT returns the FSM to IDLE. Unmasking re-arms it through the full coalescing delay.
- An async reset mid-operation clears everything immediately. primed blocks false edges after release.
- EVENTS=1: ID_W=1, o_irq_id is always 0.

Test Plan:
- Reset release with i_events=8'hFF, all sel=11 -> o_pending stays 8'h00 for 10 cycles and o_irq=0.
- sel[0]=01, mask=8'h01, coalesce=0; pulse i_events[0] 0->1 -> o_pending=8'h01 next cycle, o_irq=1 one cycle later, o_irq_id=0 with valid=1. Then clr_valid with clr_bits=8'h01 -> pending=0, and o_irq=0 two cycles after the clear.
- sel[3]=10 and sel[5]=11, mask=8'hFF; fall on bit 3 and rise on bit 5 in the same cycle -> pending=8'h28, o_irq_id=3. Clear bit 3 -> o_irq_id=5 and o_irq stays 1.
- coalesce=4, mask=8'h02, sel[1]=01; rise bit 1 -> o_irq rises exactly 5 cycles after pending sets. Repeat, clearing during HOLD -> o_irq never asserts and the FSM returns to IDLE.
- Set clear and a new edge on bit 2 in the same cycle -> pending[2] remains 1.
- mask=0 with edges on all bits -> pending=8'hFF and o_irq=0. Set mask=8'h80 -> o_irq asserts after 1+coalesce cycles with o_irq_id=7. Assert i_nrst low mid-HOLD -> all outputs 0 asynchronously.
